// File: rtl/imm_decode_stage.sv
// imm_decode_stage
//   Decode-side pipeline stage feeding the immediate extender. It registers a
//   fetched RV32I instruction and its PC behind a valid/ready handshake. A
//   2-entry skid buffer (output register + skid register) gives 1 instr/cycle
//   with a registered in_ready_o. Immediate fields are slices of the registered
//   instruction, and ext_op is decoded on the incoming word and stored per entry.
//   All extender inputs therefore come straight from registers.
//
//   Optional feature macro: IMM_DECODE_ILLEGAL_EN
//     defined   : illegal_o flags unrecognised opcodes, stored per entry
//     undefined : illegal_o tied to 0, no extra state
//
// Ports
//   clk_i         clock, rising edge
//   rstn_i        asynchronous active-low reset
//   flush_i       synchronous kill of both entries; input offered this cycle is dropped
//   in_valid_i    fetch presents an instruction
//   in_ready_o    stage can accept (= !skid_valid)
//   in_inst_i     instruction word
//   in_pc_i       instruction address
//   out_valid_o   decoded entry available
//   out_ready_i   downstream consumes entry
//   out_inst_o    registered instruction word
//   out_pc_o      registered PC
//   iimm_shamt_o  inst[24:20]
//   iimm_o        inst[31:20]
//   simm_o        {inst[31:25], inst[11:7]}
//   bimm_o        {inst[31], inst[7], inst[30:25], inst[11:8]}
//   uimm_o        inst[31:12]
//   jimm_o        {inst[31], inst[19:12], inst[20], inst[30:21]}
//   ext_op_o      extender opcode
//   illegal_o     unrecognised opcode
module imm_decode_stage #(
    parameter int         PC_W     = 32,
    parameter logic [5:0] EXT_NONE = 6'b111111
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     in_inst_i,
    input  logic [PC_W-1:0] in_pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     out_inst_o,
    output logic [PC_W-1:0] out_pc_o,
    output logic [4:0]      iimm_shamt_o,
    output logic [11:0]     iimm_o,
    output logic [11:0]     simm_o,
    output logic [11:0]     bimm_o,
    output logic [19:0]     uimm_o,
    output logic [19:0]     jimm_o,
    output logic [5:0]      ext_op_o,
    output logic            illegal_o
);

    function automatic logic [5:0] decode_ext(input logic [31:0] inst);
        logic [5:0] op;
        unique case (inst[6:0])
            7'b0010011: op = (inst[14:12] == 3'b001 || inst[14:12] == 3'b101) ? 6'b000000 : 6'b000001;
            7'b0000011,
            7'b1100111: op = 6'b000001;
            7'b0100011: op = 6'b000010;
            7'b1100011: op = 6'b000011;
            7'b0110111,
            7'b0010111: op = 6'b000100;
            7'b1101111: op = 6'b000101;
            default:    op = EXT_NONE;
        endcase
        return op;
    endfunction

    logic            out_valid_q, out_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic [31:0]     out_inst_q, out_inst_d, skid_inst_q, skid_inst_d;
    logic [PC_W-1:0] out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
    logic [5:0]      out_ext_q, out_ext_d, skid_ext_q, skid_ext_d;
    logic            fire_in, fire_out;
    logic [5:0]      new_ext;

    assign in_ready_o = !skid_valid_q;
    assign fire_in    = in_valid_i & in_ready_o;
    assign fire_out   = out_valid_q & out_ready_i;
    assign new_ext    = decode_ext(in_inst_i);

    // flush dominates; otherwise an empty or draining output register refills
    // from skid first (preserves order), then from the input. Skid drain and
    // fire_in never coincide because in_ready is low while skid is full.
    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_inst_d   = out_inst_q;
        out_pc_d     = out_pc_q;
        out_ext_d    = out_ext_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        skid_ext_d   = skid_ext_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || fire_out) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_inst_d   = skid_inst_q;
                out_pc_d     = skid_pc_q;
                out_ext_d    = skid_ext_q;
                skid_valid_d = 1'b0;
            end else if (fire_in) begin
                out_valid_d  = 1'b1;
                out_inst_d   = in_inst_i;
                out_pc_d     = in_pc_i;
                out_ext_d    = new_ext;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (fire_in) begin
            skid_valid_d = 1'b1;
            skid_inst_d  = in_inst_i;
            skid_pc_d    = in_pc_i;
            skid_ext_d   = new_ext;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_inst_q   <= '0;
            out_pc_q     <= '0;
            out_ext_q    <= EXT_NONE;
            skid_inst_q  <= '0;
            skid_pc_q    <= '0;
            skid_ext_q   <= EXT_NONE;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_inst_q   <= out_inst_d;
            out_pc_q     <= out_pc_d;
            out_ext_q    <= out_ext_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
            skid_ext_q   <= skid_ext_d;
        end
    end

`ifdef IMM_DECODE_ILLEGAL_EN
    function automatic logic decode_illegal(input logic [31:0] inst);
        logic ill;
        unique case (inst[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011: ill = 1'b0;
            default:                                         ill = 1'b1;
        endcase
        return ill;
    endfunction

    logic out_ill_q, out_ill_d, skid_ill_q, skid_ill_d;

    // Follows exactly the same load decisions as the data registers above.
    always_comb begin
        out_ill_d  = out_ill_q;
        skid_ill_d = skid_ill_q;
        if (!flush_i) begin
            if (!out_valid_q || fire_out) begin
                if (skid_valid_q)  out_ill_d = skid_ill_q;
                else if (fire_in)  out_ill_d = decode_illegal(in_inst_i);
            end else if (fire_in) begin
                skid_ill_d = decode_illegal(in_inst_i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_ill_q  <= 1'b0;
            skid_ill_q <= 1'b0;
        end else begin
            out_ill_q  <= out_ill_d;
            skid_ill_q <= skid_ill_d;
        end
    end

    assign illegal_o = out_ill_q;
`else
    assign illegal_o = 1'b0;
`endif

    assign out_valid_o  = out_valid_q;
    assign out_inst_o   = out_inst_q;
    assign out_pc_o     = out_pc_q;
    assign ext_op_o     = out_ext_q;
    assign iimm_shamt_o = out_inst_q[24:20];
    assign iimm_o       = out_inst_q[31:20];
    assign simm_o       = {out_inst_q[31:25], out_inst_q[11:7]};
    assign bimm_o       = {out_inst_q[31], out_inst_q[7], out_inst_q[30:25], out_inst_q[11:8]};
    assign uimm_o       = out_inst_q[31:12];
    assign jimm_o       = {out_inst_q[31], out_inst_q[19:12], out_inst_q[20], out_inst_q[30:21]};

endmodule

// File: tb/tb_imm_decode_stage.sv
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [4:0]  iimm_shamt;
    logic [11:0] iimm;
    logic [11:0] simm;
    logic [11:0] bimm;
    logic [19:0] uimm;
    logic [19:0] jimm;
    logic [5:0]  ext_op;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.PC_W(32), .EXT_NONE(6'b111111)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_inst_i    (in_inst),
        .in_pc_i      (in_pc),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_inst_o   (out_inst),
        .out_pc_o     (out_pc),
        .iimm_shamt_o (iimm_shamt),
        .iimm_o       (iimm),
        .simm_o       (simm),
        .bimm_o       (bimm),
        .uimm_o       (uimm),
        .jimm_o       (jimm),
        .ext_op_o     (ext_op),
        .illegal_o    (illegal)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (ext_op !== 6'h3F) begin bad++; $display("FAIL reset_ext_op got=%h exp=3f", ext_op); end
        total++; if (out_inst !== 32'h0 || out_pc !== 32'h0 || iimm !== 12'h0 || jimm !== 20'h0) begin
            bad++; $display("FAIL reset_data got inst=%h pc=%h iimm=%h jimm=%h exp all 0", out_inst, out_pc, iimm, jimm); end
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    // sel: 0 shamt, 1 iimm, 2 simm, 3 bimm, 4 uimm, 5 jimm, 6 none
    task automatic test_formats;
        logic [31:0] v_inst [9] = '{32'hFFF00093, 32'h00309093, 32'h0020A423, 32'hFE000EE3,
                                    32'h0080006F, 32'h123450B7, 32'h002081B3, 32'h0000007F,
                                    32'h00402103};
        int          v_sel  [9] = '{1, 0, 2, 3, 5, 4, 6, 6, 1};
        logic [19:0] v_fld  [9] = '{20'hFFF, 20'h3, 20'h008, 20'hFFE, 20'h00004, 20'h12345, 20'h0, 20'h0, 20'h004};
        logic [5:0]  v_ext  [9] = '{6'h01, 6'h00, 6'h02, 6'h03, 6'h05, 6'h04, 6'h3F, 6'h3F, 6'h01};
        logic        v_ill  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [19:0] obs;
        logic        exp_ill;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_inst = v_inst[i]; in_pc = 32'h1000 + 32'(i * 4);
            @(negedge clk);
            in_valid = 1'b0;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fmt%0d_valid got=%b exp=1", i, out_valid); end
            total++; if (out_inst !== v_inst[i] || out_pc !== 32'h1000 + 32'(i * 4)) begin
                bad++; $display("FAIL fmt%0d_inst_pc got=%h/%h exp=%h/%h", i, out_inst, out_pc, v_inst[i], 32'h1000 + 32'(i * 4)); end
            total++; if (ext_op !== v_ext[i]) begin bad++; $display("FAIL fmt%0d_ext_op got=%b exp=%b", i, ext_op, v_ext[i]); end
            case (v_sel[i])
                0: obs = {15'h0, iimm_shamt};
                1: obs = {8'h0, iimm};
                2: obs = {8'h0, simm};
                3: obs = {8'h0, bimm};
                4: obs = uimm;
                5: obs = jimm;
                default: obs = 20'h0;
            endcase
            if (v_sel[i] != 6) begin
                total++; if (obs !== v_fld[i]) begin bad++; $display("FAIL fmt%0d_imm got=%h exp=%h", i, obs, v_fld[i]); end
            end
`ifdef IMM_DECODE_ILLEGAL_EN
            exp_ill = v_ill[i];
`else
            exp_ill = 1'b0;
`endif
            total++; if (illegal !== exp_ill) begin bad++; $display("FAIL fmt%0d_illegal got=%b exp=%b", i, illegal, exp_ill); end
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fmt%0d_drain got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h2000;   // A
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after_A got=%b exp=1", in_ready); end
        in_inst = 32'h00200113; in_pc = 32'h2004;                    // B
        @(negedge clk);
        in_inst = 32'h00300193; in_pc = 32'h2008;                    // C
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_full got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b1 || out_inst !== 32'h00100093) begin bad++; $display("FAIL b2b_A_out got=%b/%h exp=1/00100093", out_valid, out_inst); end
        @(negedge clk);
        total++; if (out_inst !== 32'h00100093 || out_pc !== 32'h2000 || iimm !== 12'h001 || ext_op !== 6'h01) begin
            bad++; $display("FAIL b2b_A_stable got=%h/%h/%h/%b exp=00100093/2000/001/000001", out_inst, out_pc, iimm, ext_op); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_C_held got=%b exp=0", in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_inst !== 32'h00200113 || out_pc !== 32'h2004) begin
            bad++; $display("FAIL b2b_B_order got=%b/%h/%h exp=1/00200113/2004", out_valid, out_inst, out_pc); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_reopen got=%b exp=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_inst !== 32'h00300193 || iimm !== 12'h003) begin
            bad++; $display("FAIL b2b_C_order got=%b/%h/%h exp=1/00300193/003", out_valid, out_inst, iimm); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_dup got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00400213; in_pc = 32'h3000;
        @(negedge clk);
        in_inst = 32'h00500293; in_pc = 32'h3004;
        @(negedge clk);
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL flush_prefill got ready=%b valid=%b exp 0/1", in_ready, out_valid); end
        flush = 1'b1; in_inst = 32'h00600313; in_pc = 32'h3008;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_clear got valid=%b ready=%b exp 0/1", out_valid, in_ready); end
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%b exp=0", out_valid); end
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00700393; in_pc = 32'h4000;
        @(negedge clk);
        in_inst = 32'h0080006F; in_pc = 32'h4004;
        @(negedge clk);
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL areset_ctrl got valid=%b ready=%b exp 0/1", out_valid, in_ready); end
        total++; if (ext_op !== 6'h3F || out_inst !== 32'h0) begin bad++; $display("FAIL areset_data got ext=%b inst=%h exp=111111/0", ext_op, out_inst); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_skid_gone got=%b exp=0", out_valid); end
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h123450B7; in_pc = 32'h5000;
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_inst !== 32'h123450B7 || uimm !== 20'h12345 || ext_op !== 6'h04) begin
            bad++; $display("FAIL areset_first_accept got=%b/%h/%h/%b exp=1/123450b7/12345/000100", out_valid, out_inst, uimm, ext_op); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
